// File: rtl/mips_mem_pkg.sv
// Shared constants and helpers for the MIPS data-port memory responder.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    // Byte offsets of the MMIO registers from MMIO_BASE
    localparam logic [15:0] MMIO_CYCLE   = 16'h0000;
    localparam logic [15:0] MMIO_SCRATCH = 16'h0004;
    localparam logic [15:0] MMIO_STATUS  = 16'h0008;

    localparam int unsigned STATUS_ERR_BIT = 0;

    typedef enum logic {
        RD_REG = 1'b0,
        RD_RAM = 1'b1
    } rd_src_e;

    // Big-endian lanes: enable bit l owns data[8l+7:8l], so bit3 is byte offset 00
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [LANES-1:0]  wen
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int l = 0; l < LANES; l++) begin
            if (wen[l]) r[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_byte_ram.sv
// Four independent byte lanes with a synchronous read-first port; no reset so it maps onto block RAM.
module mips_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LANES-1:0]      we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (re)    rd_q      <= mem[addr];
            if (we[l]) mem[addr] <= wdata[l*LANE_W +: LANE_W];
        end

        assign rdata[l*LANE_W +: LANE_W] = rd_q;
    end

endmodule

// File: rtl/mips_data_mem_resp.sv
// Data-port responder: address decode, RAM, MMIO registers, LL/SC reservation and sticky range error.
module mips_data_mem_resp
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter logic [31:0] CYCLE_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] mem_addr,
    input  logic        mem_read_en,
    input  logic [3:0]  mem_write_en,
    input  logic [31:0] mem_write_data,
    input  logic        ll_req,
    input  logic        sc_req,
    output logic [31:0] mem_read_data,
    output logic        sc_ok,
    output logic        err_oob
);

    logic                  ram_hit;
    logic                  mmio_hit;
    logic                  oob_hit;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [13:0]           mmio_word;
    logic                  is_cycle;
    logic                  is_scratch;
    logic                  is_status;
    logic                  addr_lsb_unused;

    logic                  wr_any;
    logic                  sc_pass;
    logic [LANES-1:0]      wen_eff;
    logic [LANES-1:0]      ram_we;
    logic                  ram_re;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     mmio_rdata;

    rd_src_e               rd_src_q;
    logic [DATA_W-1:0]     rd_reg_q;
    logic [DATA_W-1:0]     cycle_q;
    logic [DATA_W-1:0]     scratch_q;
    logic                  sc_ok_q,     sc_ok_d;
    logic                  err_q,       err_d;
    logic                  res_valid_q, res_valid_d;
    logic [ADDR_WIDTH-1:0] res_idx_q,   res_idx_d;

    // Address decode; byte offset bits never select anything
    assign ram_hit         = (mem_addr[31:ADDR_WIDTH+2] == '0);
    assign mmio_hit        = (mem_addr[31:16] == MMIO_BASE[31:16]);
    assign oob_hit         = !ram_hit && !mmio_hit;
    assign word_idx        = mem_addr[ADDR_WIDTH+1:2];
    assign mmio_word       = mem_addr[15:2];
    assign is_cycle        = mmio_hit && (mmio_word == MMIO_CYCLE[15:2]);
    assign is_scratch      = mmio_hit && (mmio_word == MMIO_SCRATCH[15:2]);
    assign is_status       = mmio_hit && (mmio_word == MMIO_STATUS[15:2]);
    assign addr_lsb_unused = ^mem_addr[1:0];

    // A failing SC suppresses every lane, wherever it points
    assign wr_any  = |mem_write_en;
    assign sc_pass = ram_hit && res_valid_q && (res_idx_q == word_idx);
    assign wen_eff = (sc_req && !sc_pass) ? 4'b0000 : mem_write_en;
    assign ram_we  = (en && ram_hit) ? wen_eff : 4'b0000;
    assign ram_re  = en && mem_read_en && ram_hit;

    mips_byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .re   (ram_re),
        .addr (word_idx),
        .we   (ram_we),
        .wdata(mem_write_data),
        .rdata(ram_rdata)
    );

    // MMIO read mux; out-of-range and unmapped offsets read as zero
    always_comb begin
        mmio_rdata = '0;
        if (is_cycle)        mmio_rdata = cycle_q;
        else if (is_scratch) mmio_rdata = scratch_q;
        else if (is_status)  mmio_rdata = DATA_W'(err_q) << STATUS_ERR_BIT;
    end

    // Reservation, SC result and error flag next state
    always_comb begin
        sc_ok_d     = sc_ok_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_idx_d   = res_idx_q;
        if (en) begin
            sc_ok_d = sc_req && wr_any && sc_pass;
            if (ll_req && mem_read_en && ram_hit) begin
                res_valid_d = 1'b1;
                res_idx_d   = word_idx;
            end
            if (ram_hit && (|wen_eff) && res_valid_d && (res_idx_d == word_idx)) res_valid_d = 1'b0;
            if (sc_req) res_valid_d = 1'b0;
            if (is_status && wen_eff[STATUS_ERR_BIT] && mem_write_data[STATUS_ERR_BIT]) err_d = 1'b0;
            // A fresh error outranks a clear in the same cycle
            if (oob_hit && (mem_read_en || wr_any)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_src_q    <= RD_REG;
            rd_reg_q    <= '0;
            cycle_q     <= CYCLE_RESET;
            scratch_q   <= '0;
            sc_ok_q     <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else if (en) begin
            cycle_q     <= cycle_q + 32'd1;
            sc_ok_q     <= sc_ok_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            if (is_scratch) scratch_q <= byte_merge(scratch_q, mem_write_data, wen_eff);
            if (mem_read_en) begin
                rd_src_q <= ram_hit ? RD_RAM : RD_REG;
                rd_reg_q <= mmio_rdata;
            end
        end
    end

    assign mem_read_data = (rd_src_q == RD_RAM) ? ram_rdata : rd_reg_q;
    assign sc_ok         = sc_ok_q;
    assign err_oob       = err_q;

endmodule

// File: tb/tb_mips_data_mem_resp.sv
// Scoreboard bench for mips_data_mem_resp: directed scenarios plus randomized traffic against a reference model.
module tb_mips_data_mem_resp;

    localparam int unsigned AW       = 10;
    localparam logic [31:0] CYC_INIT = 32'hFFFF_FFFB;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_write_data;
    logic        ll_req;
    logic        sc_req;
    logic [31:0] mem_read_data;
    logic        sc_ok;
    logic        err_oob;

    always #5 clk = ~clk;

    mips_data_mem_resp #(
        .ADDR_WIDTH (AW),
        .MMIO_BASE  (32'hFFFF_0000),
        .CYCLE_RESET(CYC_INIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_write_data(mem_write_data),
        .ll_req        (ll_req),
        .sc_req        (sc_req),
        .mem_read_data (mem_read_data),
        .sc_ok         (sc_ok),
        .err_oob       (err_oob)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        sc;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [31:0] m_cycle, m_scratch, m_rd;
    logic        m_err, m_sc, m_rv;
    int          m_ridx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        if (w[3]) r[31:24] = n[31:24];
        if (w[2]) r[23:16] = n[23:16];
        if (w[1]) r[15:8]  = n[15:8];
        if (w[0]) r[7:0]   = n[7:0];
        return r;
    endfunction

    task automatic model_reset();
        m_rd = 0; m_sc = 0; m_err = 0; m_rv = 0; m_ridx = 0;
        m_cycle = CYC_INIT; m_scratch = 0;
    endtask

    task automatic model_step(input logic e, input logic [31:0] a, input logic r, input logic [3:0] w,
                              input logic [31:0] d, input logic l, input logic s);
        bit          is_ram, is_mmio, pass;
        int          idx, off;
        logic [3:0]  we;
        logic [31:0] rv;
        if (!e) return;
        is_ram  = (a < 32'(4 << AW));
        is_mmio = (a >= 32'hFFFF_0000);
        idx     = int'(a / 4) % (1 << AW);
        off     = int'((a - 32'hFFFF_0000) / 4);
        rv = 0;
        if (is_ram) rv = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        else if (is_mmio && off == 0) rv = m_cycle;
        else if (is_mmio && off == 1) rv = m_scratch;
        else if (is_mmio && off == 2) rv = {31'b0, m_err};
        pass = is_ram && m_rv && (m_ridx == idx);
        we   = (s && !pass) ? 4'b0 : w;
        m_sc = s && (w != 0) && pass;
        if (is_mmio && off == 2 && we[0] && d[0]) m_err = 0;
        if (!is_ram && !is_mmio && (r || w != 0)) m_err = 1;
        if (is_ram && we != 0) m_mem[idx] = merge(m_mem.exists(idx) ? m_mem[idx] : 32'h0, d, we);
        if (is_mmio && off == 1) m_scratch = merge(m_scratch, d, we);
        if (l && r && is_ram) begin m_rv = 1; m_ridx = idx; end
        if (is_ram && we != 0 && m_rv && m_ridx == idx) m_rv = 0;
        if (s) m_rv = 0;
        if (r) m_rd = rv;
        m_cycle = m_cycle + 1;
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic cyc(input logic e, input logic [31:0] a, input logic r, input logic [3:0] w,
                       input logic [31:0] d, input logic l, input logic s);
        exp_t x;
        @(negedge clk);
        en = e; mem_addr = a; mem_read_en = r; mem_write_en = w;
        mem_write_data = d; ll_req = l; sc_req = s;
        model_step(e, a, r, w, d, l, s);
        x.rd = m_rd; x.sc = m_sc; x.err = m_err;
        q.push_back(x);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; mem_addr = 0; mem_read_en = 0; mem_write_en = 0;
        mem_write_data = 0; ll_req = 0; sc_req = 0;
    endtask

    // Assert reset between edges and verify outputs clear without a clock
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check({tag, "_rd"},  mem_read_data, 32'h0);
        check({tag, "_sc"},  32'(sc_ok),    32'h0);
        check({tag, "_err"}, 32'(err_oob),  32'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        #1 rst = 0;
    endtask

    // Monitor: compare DUT outputs to queued expectations after each edge
    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                check("sb_rd_data", mem_read_data, x.rd);
                check("sb_sc_ok",   32'(sc_ok),    32'(x.sc));
                check("sb_err_oob", 32'(err_oob),  32'(x.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        #2 rst = 1;
        #2;
        check("reset_rd",  mem_read_data, 32'h0);
        check("reset_sc",  32'(sc_ok),    32'h0);
        check("reset_err", 32'(err_oob),  32'h0);
        @(negedge clk);
        #1 rst = 0;

        // Cycle counter: wrap and freeze
        repeat (4) cyc(1, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        cyc(1, 32'hFFFF_0000, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("cycle_max", mem_read_data, 32'hFFFF_FFFF);
        cyc(1, 32'hFFFF_0000, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("cycle_wrap", mem_read_data, 32'h0);
        repeat (3) cyc(0, 32'hFFFF_0004, 1, 4'hF, 32'hAAAA_5555, 0, 0);
        cyc(1, 32'hFFFF_0000, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("cycle_frozen", mem_read_data, 32'h1);

        // Fill the RAM words used below
        for (int i = 0; i < 24; i++) cyc(1, 32'(i * 4), 0, 4'hF, $urandom, 0, 0);

        // Partial-lane write
        cyc(1, 32'h10, 0, 4'hF, 32'hDEAD_BEEF, 0, 0);
        cyc(1, 32'h10, 0, 4'h1, 32'h0000_00AA, 0, 0);
        cyc(1, 32'h10, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("lane_merge", mem_read_data, 32'hDEAD_BEAA);

        // Read-first on a same-address read/write
        cyc(1, 32'h20, 0, 4'hF, 32'h2222_2222, 0, 0);
        cyc(1, 32'h20, 1, 4'hF, 32'h1111_1111, 0, 0);
        sample(); check("read_first_old", mem_read_data, 32'h2222_2222);
        cyc(1, 32'h20, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("read_first_new", mem_read_data, 32'h1111_1111);

        // LL/SC success, then broken by an intervening store
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 1, 0);
        cyc(1, 32'h40, 0, 4'hF, 32'h5, 0, 1);
        sample(); check("sc_success", 32'(sc_ok), 32'h1);
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("sc_stored", mem_read_data, 32'h5);
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 1, 0);
        cyc(1, 32'h40, 0, 4'hF, 32'h77, 0, 0);
        cyc(1, 32'h40, 0, 4'hF, 32'h99, 0, 1);
        sample(); check("sc_broken", 32'(sc_ok), 32'h0);
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("sc_suppressed", mem_read_data, 32'h77);

        // Out-of-range error: set, clear through STATUS, read back
        cyc(1, 32'h0001_0000, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("oob_rd", mem_read_data, 32'h0); check("oob_set", 32'(err_oob), 32'h1);
        cyc(1, 32'hFFFF_0008, 0, 4'h1, 32'h1, 0, 0);
        sample(); check("oob_clear", 32'(err_oob), 32'h0);
        cyc(1, 32'h0002_0000, 0, 4'hF, 32'h1234, 0, 0);
        cyc(1, 32'hFFFF_0008, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("status_rd", mem_read_data, 32'h1);

        // Scratch byte lanes and an unmapped MMIO word
        cyc(1, 32'hFFFF_0004, 0, 4'hF, 32'h0102_0304, 0, 0);
        cyc(1, 32'hFFFF_0004, 0, 4'h8, 32'hFF00_0000, 0, 0);
        cyc(1, 32'hFFFF_0004, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("scratch_rd", mem_read_data, 32'hFF02_0304);
        cyc(1, 32'hFFFF_0010, 1, 4'hF, 32'hFFFF_FFFF, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int unsigned k;
            logic [31:0] a;
            logic        r, l, s, e;
            logic [3:0]  w;
            k = $urandom_range(0, 9);
            if (k < 6)      a = 32'($urandom_range(0, 23)) * 4 + 32'($urandom_range(0, 3));
            else if (k < 9) a = 32'hFFFF_0000 + 32'($urandom_range(0, 4)) * 4;
            else            a = 32'h0000_1000 + ($urandom & 32'h0FFF_FFFC);
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            l = r && ($urandom_range(0, 3) == 0);
            s = (w != 0) && ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 9) != 0);
            cyc(e, a, r, w, $urandom, l, s);
        end

        // Reset after a successful SC with a pending read
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 1, 0);
        cyc(1, 32'h40, 1, 4'hF, 32'h5A5A, 0, 1);
        async_reset("rst_sc");

        // Reservation does not survive reset
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 1, 0);
        async_reset("rst_ll");
        cyc(1, 32'h40, 0, 4'hF, 32'h1234, 0, 1);
        sample(); check("sc_after_rst", 32'(sc_ok), 32'h0);
        cyc(1, 32'h40, 1, 4'h0, 32'h0, 0, 0);
        sample(); check("mem_after_rst", mem_read_data, 32'h5A5A);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
